// File: rtl/dbg_pulse_gen_if.sv
// Host register bus shared by the debug blocks: one-hot write/read strobes plus byte data.
// Latency: write strobes take effect on the next clock edge; read data is combinational.
// Backpressure: none; the host may write or read on any cycle.
interface dbg_pulse_gen_if #(
  parameter int WE_WIDTH = 8,
  parameter int RE_WIDTH = 8
);
  logic [WE_WIDTH-1:0] we_bit;
  logic [RE_WIDTH-1:0] re_bit;
  logic [7:0]          wdata;
  logic [7:0]          rdata;

  // Host side drives strobes and write data and receives read data.
  modport master (output we_bit, output re_bit, output wdata, input rdata);
  // Register block side.
  modport slave  (input we_bit, input re_bit, input wdata, output rdata);
endinterface

// File: rtl/dbg_pulse_gen.sv
// Debug pulse generator: drives sig high/low for host-programmed cycle counts, finite or continuous.
// Latency: sig/busy/done change one cycle after the state decision; register reads are combinational.
// Backpressure: none; START while busy is ignored, STOP always wins and returns to idle.
module dbg_pulse_gen #(
  parameter int C_CNT_WH = 12,
  parameter int WE_WIDTH = 8,
  parameter int RE_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  dbg_pulse_gen_if.slave   host,
  output logic             sig,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t              state;
  logic [C_CNT_WH-1:0] hi_len;
  logic [C_CNT_WH-1:0] lo_len;
  logic [7:0]          rep;
  logic                cont;
  logic                idle_lvl;
  logic [C_CNT_WH-1:0] cnt;
  logic [7:0]          remain;

  // Control strobes and the post-write view of the stored control bits.
  logic ctrl_wr;
  logic start;
  logic stop;
  logic cont_next;
  logic idle_next;
  logic [7:0] rep_next;
  logic re_one_hot;

  assign ctrl_wr   = host.we_bit[0];
  assign start     = ctrl_wr & host.wdata[0];
  assign stop      = ctrl_wr & host.wdata[1];
  assign cont_next = ctrl_wr ? host.wdata[2] : cont;
  assign idle_next = ctrl_wr ? host.wdata[3] : idle_lvl;
  assign rep_next  = host.we_bit[5] ? host.wdata : rep;

  // Strobe bits above the register map have no effect.
  if (WE_WIDTH > 6) begin : g_we_spare
    logic unused_we;
    assign unused_we = ^host.we_bit[WE_WIDTH-1:6];
  end

  // A zero length still yields a one-cycle phase so the counter never wraps.
  function automatic logic [C_CNT_WH-1:0] eff(input logic [C_CNT_WH-1:0] x);
    return (x == '0) ? C_CNT_WH'(1) : x;
  endfunction

  // Host-writable configuration registers; multiple strobes in one cycle all apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_len   <= '0;
      lo_len   <= '0;
      rep      <= '0;
      cont     <= 1'b0;
      idle_lvl <= 1'b0;
    end else begin
      if (host.we_bit[0]) begin
        cont     <= host.wdata[2];
        idle_lvl <= host.wdata[3];
      end
      if (host.we_bit[1]) hi_len[7:0]          <= host.wdata;
      if (host.we_bit[2]) hi_len[C_CNT_WH-1:8] <= host.wdata[C_CNT_WH-9:0];
      if (host.we_bit[3]) lo_len[7:0]          <= host.wdata;
      if (host.we_bit[4]) lo_len[C_CNT_WH-1:8] <= host.wdata[C_CNT_WH-9:0];
      if (host.we_bit[5]) rep                  <= host.wdata;
    end
  end

  // Phase sequencer: owns state, phase counter, period budget and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      remain <= '0;
      sig    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state  <= IDLE;
        remain <= '0;
        sig    <= idle_next;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sig  <= idle_next;
            busy <= 1'b0;
            if (start && (cont_next || rep_next != 8'd0)) begin
              state  <= HIGH;
              sig    <= 1'b1;
              busy   <= 1'b1;
              cnt    <= eff(hi_len);
              remain <= rep_next;
            end
          end
          HIGH: begin
            if (cnt == C_CNT_WH'(1)) begin
              state <= LOW;
              sig   <= 1'b0;
              cnt   <= eff(lo_len);
            end else begin
              cnt <= cnt - C_CNT_WH'(1);
            end
          end
          LOW: begin
            if (cnt == C_CNT_WH'(1)) begin
              if (cont_next) begin
                state <= HIGH;
                sig   <= 1'b1;
                cnt   <= eff(hi_len);
              end else if (remain <= 8'd1) begin
                // Last period done (or continuous mode dropped with no budget left).
                state  <= IDLE;
                remain <= '0;
                sig    <= idle_next;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                state  <= HIGH;
                sig    <= 1'b1;
                cnt    <= eff(hi_len);
                remain <= remain - 8'd1;
              end
            end else begin
              cnt <= cnt - C_CNT_WH'(1);
            end
          end
          default: begin
            state <= IDLE;
            sig   <= idle_next;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign re_one_hot = (host.re_bit != '0) &&
                      ((host.re_bit & (host.re_bit - RE_WIDTH'(1))) == '0);

  // Read mux; anything other than a single select bit reads as zero.
  always_comb begin
    host.rdata = 8'h00;
    if (re_one_hot) begin
      if      (host.re_bit[0]) host.rdata = {5'b0, idle_lvl, cont, busy};
      else if (host.re_bit[1]) host.rdata = hi_len[7:0];
      else if (host.re_bit[2]) host.rdata = 8'(hi_len[C_CNT_WH-1:8]);
      else if (host.re_bit[3]) host.rdata = lo_len[7:0];
      else if (host.re_bit[4]) host.rdata = 8'(lo_len[C_CNT_WH-1:8]);
      else if (host.re_bit[5]) host.rdata = rep;
      else if (host.re_bit[6]) host.rdata = remain;
      else if (host.re_bit[7]) host.rdata = {6'b0, state};
      else                     host.rdata = 8'h00;
    end
  end

endmodule
